mem_access: RTL
===============

// Module: mem_access
// PURPOSE
//   MEM-stage load/store unit of the CPU pipeline. Takes the ALU-computed address and store data.
//   Runs one word-aligned transaction per instruction on the data-bus req/ack interface.
//   Returns the aligned, sign/zero-extended load value on dram_rd_data, which writeback selects for rf_wr_data.
//   Stalls the pipeline while the bus access is outstanding.
// PARAMETERS
//   TIMEOUT  255  max cycles dbus_req may stay unacknowledged before bus_err (>=1)
// PORTS
//   clk           in   1   single clock; all state updates on posedge
//   rst           in   1   synchronous, active-high reset
//   mem_en        in   1   current MEM-stage instruction is a load or store
//   mem_we        in   1   1 = store, 0 = load (valid with mem_en)
//   funct3        in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
//   addr          in   32  byte address from ALU
//   wr_data       in   32  store data (rs2)
//   stall         out  1   hold IF..MEM pipeline regs this cycle
//   done          out  1   1-cycle pulse: access finished (ok, misaligned or bus error)
//   misalign      out  1   valid with done: misaligned address or illegal funct3
//   bus_err       out  1   valid with done: ack timeout
//   dram_rd_data  out  32  extended load result; held until the next completed load
//   dbus_req      out  1   bus request, registered
//   dbus_we       out  1   bus write enable
//   dbus_addr     out  32  {addr[31:2],2'b00}
//   dbus_be       out  4   byte enables
//   dbus_wdata    out  32  lane-replicated store data
//   dbus_ack      in   1   slave accepts/completes the request in this cycle
//   dbus_rdata    in   32  read data, valid when dbus_ack=1 and dbus_we=0
// BEHAVIOUR
//   Reset: state IDLE, timeout counter 0.
//   Reset: stall, done, misalign, bus_err, dram_rd_data, and all dbus_* outputs are 0.
//   FSM states: IDLE, REQ, DONE.
//   IDLE:
//     - mem_en=1 raises stall combinationally.
//     - Operands latched into internal regs.
//     - Aligned and legal -> REQ.
//     - Otherwise -> DONE with misalign=1; no bus access; dram_rd_data unchanged.
//   Alignment rules:
//     - H/HU need addr[0]=0.
//     - W needs addr[1:0]=0.
//     - funct3 011/110/111 is illegal; BU/HU with mem_we=1 is illegal.
//   REQ:
//     - dbus_req=1 and stall=1; dbus_* outputs are stable for the whole state.
//     - dbus_ack=1 -> DONE. If a load, dram_rd_data <= extended dbus_rdata in that same edge.
//     - The counter increments each REQ cycle. Reaching TIMEOUT without ack -> DONE with bus_err=1.
//     - On timeout, dram_rd_data <= 0 for loads.
//   DONE:
//     - done=1 and stall=0; the pipeline advances this cycle.
//     - Next state is always IDLE.
//     - mem_en is ignored in DONE: it still belongs to the retiring instruction.
//   Minimum latency: 2 stall cycles (IDLE, REQ with immediate ack), then the DONE cycle.
//   Store byte lanes:
//     - SB: be = 4'b0001<<addr[1:0], wdata = {4{wr_data[7:0]}}.
//     - SH: be = 4'b0011<<{addr[1],1'b0}, wdata = {2{wr_data[15:0]}}.
//     - SW: be = 4'b1111, wdata = wr_data.
//   Load data path:
//     - Loads drive be=4'b1111.
//     - Extract rdata>>(8*addr[1:0]) at byte or half width.
//     - Sign-extend when funct3[2]=0, zero-extend otherwise.
//   Ordering and stray inputs:
//     - Stores never modify dram_rd_data.
//     - dbus_ack outside REQ is ignored.
//     - Ack in the same cycle as the timeout expiry counts as success (ack has priority).
//   Reset mid-operation:
//     - rst in any state -> IDLE next edge, dbus_req=0.
//     - Any in-flight ack after reset is ignored.
// STRUCTURE
//   cpu.vh: FUNCT3_{LB,LH,LW,LBU,LHU,SB,SH,SW} constants and MEM_{IDLE,REQ,DONE} state encodings.
//   Sub-module mem_align is purely combinational:
//     - Inputs: funct3, addr[1:0], wr_data, rdata.
//     - Outputs: be, wdata, load_ext, misalign.
//   mem_access owns the FSM, the timeout counter, the latched operands and the output registers.
// TESTING
//   1. LW, addr=0x100, ack on the first REQ cycle, rdata=0xDEADBEEF:
//      stall for 2 cycles, done in cycle 3, dram_rd_data=0xDEADBEEF, dbus_addr=0x100, be=4'hF.
//   2. LB addr=0x203, rdata=0x80FF_FF7F -> dram_rd_data=0xFFFFFF80.
//      LBU at the same addr -> 0x00000080.
//      LHU addr=0x202, rdata=0xBEEF1234 -> 0x0000BEEF.
//   3. SB addr=0x1, wr_data=0x123456AB -> dbus_be=4'b0010, dbus_wdata=0xABABABAB, dbus_we=1.
//      SH addr=0x2 -> be=4'b1100.
//      A store does not alter dram_rd_data.
//   4. LW addr=0x102 or LH addr=0x1: no dbus_req ever, done=1 and misalign=1 in the 2nd cycle, stall for 1 cycle.
//      Same response for funct3=3'b011.
//   5. TIMEOUT=4, ack never asserted: dbus_req high for 4 cycles, then done=1, bus_err=1, dram_rd_data=0.
//      Repeat with ack in the 4th cycle -> success, bus_err=0.
//   6. Assert rst during REQ: next cycle state IDLE, dbus_req=0, all outputs 0.
//      A late ack is ignored; the next LW completes normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: funct3 encodings and MEM-stage FSM states shared by the load/store unit
package mem_access_pkg;
  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;
  typedef enum logic [1:0] {MEM_IDLE, MEM_REQ, MEM_DONE} mem_state_t;
endpackage

// File: rtl/mem_align.sv
// mem_align: combinational byte-lane steering for stores and extraction/extension for loads (funct3, addr[1:0], wr_data, rdata -> be, wdata, load_ext, misalign)
module mem_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] wr_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_ext,
  output logic        misalign
);
  logic [31:0] sh;
  logic        sx;
  assign sh = rdata >> {addr, 3'b000};
  assign sx = ~funct3[2];
  assign be = (funct3 == FUNCT3_SB) ? 4'b0001 << addr :
              (funct3 == FUNCT3_SH) ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
  assign wdata = (funct3 == FUNCT3_SB) ? {4{wr_data[7:0]}} :
                 (funct3 == FUNCT3_SH) ? {2{wr_data[15:0]}} : wr_data;
  assign load_ext = (funct3[1:0] == 2'b00) ? {{24{sx & sh[7]}}, sh[7:0]} :
                    (funct3[1:0] == 2'b01) ? {{16{sx & sh[15]}}, sh[15:0]} : rdata;
  assign misalign = !(funct3 inside {FUNCT3_LB, FUNCT3_LH, FUNCT3_LW, FUNCT3_LBU, FUNCT3_LHU})
                  | ((funct3 == FUNCT3_LH || funct3 == FUNCT3_LHU) && addr[0])
                  | (funct3 == FUNCT3_LW && addr != 2'b00);
endmodule

// File: rtl/mem_access.sv
// mem_access: MEM-stage load/store unit; one word-aligned req/ack bus transaction per instruction, stalls the pipeline while outstanding (ports: mem_en/we/funct3/addr/wr_data in, stall/done/misalign/bus_err/dram_rd_data out, dbus_* master)
module mem_access #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic        stall,
  output logic        done,
  output logic        misalign,
  output logic        bus_err,
  output logic [31:0] dram_rd_data,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata
);
  import mem_access_pkg::*;
  localparam int CW = $clog2(TIMEOUT + 1);
  mem_state_t  state;
  logic [2:0]  f3_q;
  logic [1:0]  a_q;
  logic        we_q;
  logic [CW-1:0] cnt;
  logic        idle, bad, illegal, expired;
  logic [2:0]  f3;
  logic [1:0]  a;
  logic [3:0]  be;
  logic [31:0] wdata, load_ext;
  assign idle = state == MEM_IDLE;
  // the aligner sees live inputs while deciding in IDLE, latched operands while the bus is busy
  assign f3 = idle ? funct3 : f3_q;
  assign a = idle ? addr[1:0] : a_q;
  mem_align u_align (
    .funct3(f3), .addr(a), .wr_data(wr_data), .rdata(dbus_rdata),
    .be(be), .wdata(wdata), .load_ext(load_ext), .misalign(bad)
  );
  assign illegal = bad | (mem_we & funct3[2]);
  assign expired = cnt == CW'(TIMEOUT - 1);
  assign stall = (idle & mem_en) | (state == MEM_REQ);
  assign done = state == MEM_DONE;
  assign dbus_req = state == MEM_REQ;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MEM_IDLE;
      cnt <= '0;
      f3_q <= '0;
      a_q <= '0;
      we_q <= 1'b0;
      misalign <= 1'b0;
      bus_err <= 1'b0;
      dram_rd_data <= '0;
      dbus_we <= 1'b0;
      dbus_addr <= '0;
      dbus_be <= '0;
      dbus_wdata <= '0;
    end else begin
      case (state)
        MEM_IDLE: begin
          cnt <= '0;
          bus_err <= 1'b0;
          misalign <= mem_en & illegal;
          if (mem_en) begin
            f3_q <= funct3;
            a_q <= addr[1:0];
            we_q <= mem_we;
            state <= illegal ? MEM_DONE : MEM_REQ;
            if (!illegal) begin
              dbus_we <= mem_we;
              dbus_addr <= {addr[31:2], 2'b00};
              dbus_be <= mem_we ? be : 4'b1111;
              dbus_wdata <= wdata;
            end
          end
        end
        MEM_REQ: begin
          cnt <= cnt + 1'b1;
          // ack wins over a timeout expiring in the same cycle
          if (dbus_ack || expired) begin
            state <= MEM_DONE;
            bus_err <= !dbus_ack;
            if (!we_q) dram_rd_data <= dbus_ack ? load_ext : '0;
          end
        end
        MEM_DONE: begin
          state <= MEM_IDLE;
          misalign <= 1'b0;
          bus_err <= 1'b0;
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end
endmodule
